// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID register and run-control FSM
// (continuous / single-step / halted) with stall and redirect handling.
module instruction_fetch (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic        i_step,
  input  logic        i_stall,
  input  logic        i_pc_load,
  input  logic [31:0] i_pc_target,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_next,
  output logic        o_valid,
  output logic        o_pipe_en,
  output logic        o_halted,
  output logic [31:0] o_instr_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] count_q, count_d;
  logic        adv;
  logic        is_halt;

  assign is_halt = (i_imem_data == HALT_WORD);

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      pc_q      <= 32'd0;
      instr_q   <= 32'd0;
      pc_next_q <= 32'd0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic; mode is captured only on the IDLE start transition.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mode_d  = i_mode;
          state_d = i_mode ? S_STEP : S_RUN;
        end
      end
      S_RUN, S_STEP: begin
        if (adv && !i_pc_load && is_halt) state_d = S_HALTED;
      end
      default: state_d = state_q;
    endcase
  end

  // Output logic: pipe enable ignores stall, so a step pulse during stall is consumed.
  always_comb begin
    o_pipe_en = 1'b0;
    case (state_q)
      S_RUN:    o_pipe_en = 1'b1;
      S_STEP:   o_pipe_en = i_step;
      S_HALTED: o_pipe_en = !mode_q || i_step;
      default:  o_pipe_en = 1'b0;
    endcase
    adv = ((state_q == S_RUN) || ((state_q == S_STEP) && i_step)) && !i_stall;
  end

  // Datapath: redirect beats HALT detection, which beats sequential fetch.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    count_d   = count_q;
    if (adv) begin
      if (i_pc_load) begin
        pc_d    = {i_pc_target[31:2], 2'b00};
        instr_d = 32'd0;
        valid_d = 1'b0;
      end else if (is_halt) begin
        instr_d  = 32'd0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end else begin
        instr_d   = i_imem_data;
        pc_next_d = pc_q + 32'd4;
        valid_d   = 1'b1;
        pc_d      = pc_q + 32'd4;
        count_d   = count_q + 32'd1;
      end
    end else if ((state_q == S_HALTED) && o_pipe_en) begin
      instr_d = 32'd0;
      valid_d = 1'b0;
    end
  end

  assign o_imem_addr   = pc_q;
  assign o_instr       = instr_q;
  assign o_pc_next     = pc_next_q;
  assign o_valid       = valid_q;
  assign o_halted      = halted_q;
  assign o_instr_count = count_q;
  assign o_state       = state_q;

endmodule
